// File: rtl/ip_mem_arbiter.sv
// Instruction-memory arbiter: round-robin between the CPU fetch port and the loader port,
// one outstanding memory transaction at a time, with a bounded WAIT and a sticky timeout flag.
module ip_mem_arbiter #(
   parameter int ADDR_WIDTH = 24,
   parameter int INSN_WIDTH = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  FetchReq,
   input  logic [ADDR_WIDTH-1:0] FetchAddr,
   output logic                  FetchReady,
   output logic [INSN_WIDTH-1:0] FetchInsn,
   input  logic                  LoadReq,
   input  logic                  LoadWE,
   input  logic [ADDR_WIDTH-1:0] LoadAddr,
   input  logic [INSN_WIDTH-1:0] LoadData,
   output logic                  LoadReady,
   output logic [INSN_WIDTH-1:0] LoadInsn,
   output logic                  MemRequest,
   output logic                  MemWE,
   output logic [ADDR_WIDTH-1:0] MemAddress,
   output logic [INSN_WIDTH-1:0] MemInsnIn,
   input  logic [INSN_WIDTH-1:0] MemInsnOut,
   input  logic                  MemReady,
   output logic                  Busy,
   output logic                  TimeoutErr
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   localparam logic GRANT_FETCH = 1'b0;
   localparam logic GRANT_LOAD  = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  r_last_grant;
   logic                  r_winner;
   logic                  r_load_we;
   logic [CNT_W-1:0]      r_wait_cnt;
   logic [CNT_W-1:0]      w_wait_cnt_nxt;
   logic                  w_grant;
   logic                  w_winner;
   logic                  w_capture;
   logic                  w_timeout;
   logic [ADDR_WIDTH-1:0] w_grant_addr;

   logic                  r_mem_request;
   logic                  r_mem_we;
   logic [ADDR_WIDTH-1:0] r_mem_addr;
   logic [INSN_WIDTH-1:0] r_mem_wdata;
   logic                  r_fetch_ready;
   logic                  r_load_ready;
   logic [INSN_WIDTH-1:0] r_fetch_insn;
   logic [INSN_WIDTH-1:0] r_load_insn;
   logic                  r_busy;
   logic                  r_timeout_err;

   assign w_grant_addr = (w_winner == GRANT_LOAD) ? LoadAddr : FetchAddr;

   always_comb begin
      w_state_nxt    = r_state;
      w_wait_cnt_nxt = r_wait_cnt;
      w_grant        = 1'b0;
      w_winner       = r_winner;
      w_capture      = 1'b0;
      w_timeout      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (FetchReq || LoadReq) begin
               w_grant     = 1'b1;
               w_state_nxt = S_ISSUE;
               // On a tie the side that did not win last time gets the memory.
               if (FetchReq && LoadReq) begin
                  w_winner = ~r_last_grant;
               end else if (LoadReq) begin
                  w_winner = GRANT_LOAD;
               end else begin
                  w_winner = GRANT_FETCH;
               end
            end else begin
               w_state_nxt = S_IDLE;
            end
         end
         S_ISSUE: begin
            w_state_nxt    = S_WAIT;
            w_wait_cnt_nxt = CNT_ZERO;
         end
         S_WAIT: begin
            if (MemReady) begin
               w_capture   = 1'b1;
               w_state_nxt = S_DONE;
            end else if (r_wait_cnt == CNT_LAST) begin
               w_timeout   = 1'b1;
               w_state_nxt = S_DONE;
            end else begin
               w_wait_cnt_nxt = r_wait_cnt + CNT_ONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_state      <= S_IDLE;
         r_wait_cnt   <= CNT_ZERO;
         r_last_grant <= GRANT_LOAD;
         r_winner     <= GRANT_FETCH;
         r_load_we    <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_wait_cnt <= w_wait_cnt_nxt;
         if (w_grant) begin
            r_winner     <= w_winner;
            r_last_grant <= w_winner;
            r_load_we    <= (w_winner == GRANT_LOAD) & LoadWE;
         end else begin
            r_winner     <= r_winner;
            r_last_grant <= r_last_grant;
            r_load_we    <= r_load_we;
         end
      end
   end

   // Memory-side outputs are decoded from the next state so they line up with the state register.
   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_mem_request <= 1'b0;
         r_mem_we      <= 1'b0;
         r_mem_addr    <= {ADDR_WIDTH{1'b0}};
         r_mem_wdata   <= {INSN_WIDTH{1'b0}};
         r_busy        <= 1'b0;
      end else begin
         r_mem_request <= w_grant;
         r_mem_we      <= w_grant & (w_winner == GRANT_LOAD) & LoadWE;
         r_busy        <= (w_state_nxt != S_IDLE);
         if (w_grant) begin
            r_mem_addr  <= w_grant_addr;
            r_mem_wdata <= LoadData;
         end else begin
            r_mem_addr  <= r_mem_addr;
            r_mem_wdata <= r_mem_wdata;
         end
      end
   end

   always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
         r_fetch_ready <= 1'b0;
         r_load_ready  <= 1'b0;
         r_fetch_insn  <= {INSN_WIDTH{1'b0}};
         r_load_insn   <= {INSN_WIDTH{1'b0}};
         r_timeout_err <= 1'b0;
      end else begin
         r_fetch_ready <= (w_state_nxt == S_DONE) & (r_winner == GRANT_FETCH);
         r_load_ready  <= (w_state_nxt == S_DONE) & (r_winner == GRANT_LOAD);
         r_timeout_err <= r_timeout_err | w_timeout;
         // Loader writes complete without touching either read-back register.
         if (w_capture && (r_winner == GRANT_FETCH)) begin
            r_fetch_insn <= MemInsnOut;
         end else begin
            r_fetch_insn <= r_fetch_insn;
         end
         if (w_capture && (r_winner == GRANT_LOAD) && !r_load_we) begin
            r_load_insn <= MemInsnOut;
         end else begin
            r_load_insn <= r_load_insn;
         end
      end
   end

   assign MemRequest = r_mem_request;
   assign MemWE      = r_mem_we;
   assign MemAddress = r_mem_addr;
   assign MemInsnIn  = r_mem_wdata;
   assign FetchReady = r_fetch_ready;
   assign LoadReady  = r_load_ready;
   assign FetchInsn  = r_fetch_insn;
   assign LoadInsn   = r_load_insn;
   assign Busy       = r_busy;
   assign TimeoutErr = r_timeout_err;

endmodule

// File: tb/tb_ip_mem_arbiter.sv
// Randomized scoreboard bench for ip_mem_arbiter: a transaction-level model predicts grant order,
// read data, timeouts and latency; a memory responder and a monitor check the DUT against it.
module tb_ip_mem_arbiter;

   localparam int AW  = 24;
   localparam int IW  = 4;
   localparam int TMO = 15;

   typedef struct {
      logic          who;     // 0 = fetch, 1 = loader
      logic [AW-1:0] addr;
      logic          we;
      logic [IW-1:0] data;
      int            d;       // memory response delay in cycles, 0 = never responds
      bit            drop;    // drop the request right after it is granted
      logic [IW-1:0] fins;
      logic [IW-1:0] lins;
      logic          terr;
   } txn_t;

   logic          Clk, Rst;
   logic          FetchReq, FetchReady, LoadReq, LoadWE, LoadReady;
   logic          MemRequest, MemWE, MemReady, Busy, TimeoutErr;
   logic [AW-1:0] FetchAddr, LoadAddr, MemAddress;
   logic [IW-1:0] FetchInsn, LoadData, LoadInsn, MemInsnIn, MemInsnOut;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   mreq_cnt = 0;
   int   req_cyc = 0;
   txn_t expq[$];
   txn_t fq[$];
   txn_t lq[$];
   logic [IW-1:0] ref_mem [logic [AW-1:0]];
   logic [IW-1:0] dev_mem [logic [AW-1:0]];
   logic [AW-1:0] pool [8];
   logic          m_last;
   logic [IW-1:0] m_fins, m_lins;
   logic          m_terr;

   ip_mem_arbiter #(.ADDR_WIDTH(AW), .INSN_WIDTH(IW), .TIMEOUT(TMO)) dut (
      .Clk(Clk), .Rst(Rst),
      .FetchReq(FetchReq), .FetchAddr(FetchAddr), .FetchReady(FetchReady), .FetchInsn(FetchInsn),
      .LoadReq(LoadReq), .LoadWE(LoadWE), .LoadAddr(LoadAddr), .LoadData(LoadData),
      .LoadReady(LoadReady), .LoadInsn(LoadInsn),
      .MemRequest(MemRequest), .MemWE(MemWE), .MemAddress(MemAddress), .MemInsnIn(MemInsnIn),
      .MemInsnOut(MemInsnOut), .MemReady(MemReady), .Busy(Busy), .TimeoutErr(TimeoutErr)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   always @(posedge Clk) cyc <= cyc + 1;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [IW-1:0] mem_init(input logic [AW-1:0] a);
      return a[3:0] ^ a[7:4] ^ a[23:20] ^ 4'h5;
   endfunction

   function automatic logic [IW-1:0] ref_read(input logic [AW-1:0] a);
      return ref_mem.exists(a) ? ref_mem[a] : mem_init(a);
   endfunction

   function automatic logic [IW-1:0] dev_read(input logic [AW-1:0] a);
      return dev_mem.exists(a) ? dev_mem[a] : mem_init(a);
   endfunction

   function automatic int rand_d();
      return ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5));
   endfunction

   task automatic mem_set(input logic [AW-1:0] a, input logic [IW-1:0] v);
      ref_mem[a] = v;
      dev_mem[a] = v;
   endtask

   task automatic model_reset();
      m_last = 1'b1;
      m_fins = '0;
      m_lins = '0;
      m_terr = 1'b0;
   endtask

   task automatic add_f(input logic [AW-1:0] a, input int d, input bit drop);
      txn_t t;
      t.who = 1'b0; t.addr = a; t.we = 1'b0; t.data = '0; t.d = d; t.drop = drop;
      t.fins = '0; t.lins = '0; t.terr = 1'b0;
      fq.push_back(t);
   endtask

   task automatic add_l(input logic [AW-1:0] a, input logic we, input logic [IW-1:0] v,
                        input int d, input bit drop);
      txn_t t;
      t.who = 1'b1; t.addr = a; t.we = we; t.data = v; t.d = d; t.drop = drop;
      t.fins = '0; t.lins = '0; t.terr = 1'b0;
      lq.push_back(t);
   endtask

   // Memory device: answers each request after the planned delay, otherwise toggles MemReady at random.
   initial begin
      logic          rs_act;
      int            rs_cnt, rs_d;
      logic [AW-1:0] rs_a;
      logic          rs_w;
      logic [IW-1:0] rs_wd;
      rs_act = 1'b0; rs_cnt = 0; rs_d = 0; rs_a = '0; rs_w = 1'b0; rs_wd = '0;
      MemReady = 1'b0;
      MemInsnOut = '0;
      forever begin
         @(negedge Clk);
         if (Rst) begin
            rs_act = 1'b0;
            MemReady = 1'b0;
         end else if (MemRequest) begin
            rs_d = (expq.size() > 0) ? expq[0].d : 0;
            rs_act = 1'b1; rs_cnt = 0;
            rs_a = MemAddress; rs_w = MemWE; rs_wd = MemInsnIn;
            MemReady = ($urandom_range(0, 1) == 0);
            MemInsnOut = IW'($urandom);
         end else if (rs_act) begin
            rs_cnt++;
            MemReady = 1'b0;
            MemInsnOut = IW'($urandom);
            if (rs_d != 0 && rs_cnt == rs_d) begin
               MemReady = 1'b1;
               if (rs_w) dev_mem[rs_a] = rs_wd;
               else MemInsnOut = dev_read(rs_a);
               rs_act = 1'b0;
            end else if (rs_d == 0 && rs_cnt >= TMO + 1) begin
               rs_act = 1'b0;
            end
         end else begin
            MemReady = ($urandom_range(0, 3) == 0);
            MemInsnOut = IW'($urandom);
         end
      end
   end

   // Monitor: checks each memory request and pops one expectation per Ready pulse.
   initial begin
      txn_t it;
      forever begin
         @(negedge Clk);
         if (Rst) begin
            mreq_cnt = 0;
         end else begin
            if (MemWE) chk("memwe_only_in_issue", 32'(MemRequest), 32'd1);
            if (MemRequest) begin
               mreq_cnt++;
               req_cyc = cyc;
               chk("busy_during_request", 32'(Busy), 32'd1);
               if (expq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_memrequest: addr 0x%0h with no transaction pending", MemAddress);
               end else begin
                  it = expq[0];
                  chk("mem_address", 32'(MemAddress), 32'(it.addr));
                  chk("mem_we", 32'(MemWE), 32'(it.who & it.we));
                  if (it.who && it.we) chk("mem_wdata", 32'(MemInsnIn), 32'(it.data));
               end
            end
            if (FetchReady || LoadReady) begin
               chk("ready_exclusive", 32'(FetchReady & LoadReady), 32'd0);
               if (expq.size() == 0) begin
                  checks++; errors++;
                  $display("FAIL unexpected_ready: fetch %0b load %0b with nothing expected", FetchReady, LoadReady);
               end else begin
                  it = expq.pop_front();
                  chk("ready_who", 32'({FetchReady, LoadReady}), it.who ? 32'd1 : 32'd2);
                  chk("fetch_insn", 32'(FetchInsn), 32'(it.fins));
                  chk("load_insn", 32'(LoadInsn), 32'(it.lins));
                  chk("timeout_err", 32'(TimeoutErr), 32'(it.terr));
                  chk("mem_requests_per_txn", 32'(mreq_cnt), 32'd1);
                  chk("latency", 32'(cyc - req_cyc), (it.d == 0) ? 32'(TMO + 1) : 32'(it.d + 1));
                  chk("busy_in_done", 32'(Busy), 32'd1);
               end
               mreq_cnt = 0;
            end
         end
      end
   end

   // Predicts the grant order for the queued requests, then drives and holds the request lines.
   task automatic run_round();
      int   fi, li, k, done, total, budget, fcur, lcur;
      logic w;
      txn_t t;
      logic order[$];
      fi = 0; li = 0;
      while (fi < fq.size() || li < lq.size()) begin
         if (fi < fq.size() && li < lq.size()) w = ~m_last;
         else w = (li < lq.size());
         if (w) begin t = lq[li]; li++; end
         else begin t = fq[fi]; fi++; end
         if (t.d == 0) m_terr = 1'b1;
         else if (!w) m_fins = ref_read(t.addr);
         else if (t.we) ref_mem[t.addr] = t.data;
         else m_lins = ref_read(t.addr);
         t.fins = m_fins; t.lins = m_lins; t.terr = m_terr;
         expq.push_back(t);
         order.push_back(w);
         m_last = w;
      end
      total = order.size();
      budget = total * (TMO + 8) + 8;
      k = 0; done = 0; fcur = 0; lcur = 0;
      @(negedge Clk);
      if (fq.size() > 0) begin
         FetchReq = 1'b1; FetchAddr = fq[0].addr;
      end
      if (lq.size() > 0) begin
         LoadReq = 1'b1; LoadAddr = lq[0].addr; LoadWE = lq[0].we; LoadData = lq[0].data;
      end
      while (done < total && budget > 0) begin
         @(negedge Clk);
         budget--;
         if (MemRequest && k < total) begin
            if (order[k] == 1'b0) begin
               if (fcur < fq.size() && fq[fcur].drop && fcur == fq.size() - 1) FetchReq = 1'b0;
            end else begin
               if (lcur < lq.size() && lq[lcur].drop && lcur == lq.size() - 1) LoadReq = 1'b0;
            end
            k++;
         end
         if (FetchReady) begin
            fcur++; done++;
            if (fcur < fq.size()) FetchAddr = fq[fcur].addr;
            else FetchReq = 1'b0;
         end
         if (LoadReady) begin
            lcur++; done++;
            if (lcur < lq.size()) begin
               LoadAddr = lq[lcur].addr; LoadWE = lq[lcur].we; LoadData = lq[lcur].data;
            end else begin
               LoadReq = 1'b0;
            end
         end
      end
      FetchReq = 1'b0;
      LoadReq = 1'b0;
      if (done < total) begin
         checks++; errors++;
         $display("FAIL round_timeout: completed %0d of %0d transactions", done, total);
         expq.delete();
      end else begin
         @(negedge Clk);
         chk("idle_after_round", 32'(Busy), 32'd0);
      end
      fq.delete();
      lq.delete();
   endtask

   // Starts a fetch that the memory never answers and resets wcyc cycles after the request.
   task automatic reset_mid(input int wcyc);
      txn_t t;
      int   b;
      t.who = 1'b0; t.addr = pool[5]; t.we = 1'b0; t.data = '0; t.d = 0; t.drop = 1'b0;
      t.fins = m_fins; t.lins = m_lins; t.terr = m_terr;
      expq.push_back(t);
      @(negedge Clk);
      FetchReq = 1'b1;
      FetchAddr = pool[5];
      b = 0;
      do begin
         @(negedge Clk);
         b++;
      end while (!MemRequest && b < 10);
      chk("rst_mid_request_seen", 32'(MemRequest), 32'd1);
      if (wcyc > 0) begin
         repeat (wcyc) @(posedge Clk);
         #2;
      end
      Rst = 1'b1;
      #1;
      chk("rst_mid_memrequest", 32'(MemRequest), 32'd0);
      chk("rst_mid_memwe", 32'(MemWE), 32'd0);
      chk("rst_mid_busy", 32'(Busy), 32'd0);
      chk("rst_mid_timeout_err", 32'(TimeoutErr), 32'd0);
      chk("rst_mid_fetch_insn", 32'(FetchInsn), 32'd0);
      chk("rst_mid_fetch_ready", 32'(FetchReady), 32'd0);
      FetchReq = 1'b0;
      expq.delete();
      model_reset();
      repeat (3) @(negedge Clk);
      Rst = 1'b0;
      repeat (TMO + 4) @(negedge Clk);
      chk("rst_mid_stays_idle", 32'(Busy), 32'd0);
   endtask

   initial begin
      Rst = 1'b0; FetchReq = 1'b0; FetchAddr = '0;
      LoadReq = 1'b0; LoadWE = 1'b0; LoadAddr = '0; LoadData = '0;
      foreach (pool[i]) pool[i] = AW'($urandom);
      model_reset();
      #1 Rst = 1'b1;
      #2;
      chk("reset_memrequest", 32'(MemRequest), 32'd0);
      chk("reset_memwe", 32'(MemWE), 32'd0);
      chk("reset_memaddress", 32'(MemAddress), 32'd0);
      chk("reset_meminsnin", 32'(MemInsnIn), 32'd0);
      chk("reset_readys", 32'({FetchReady, LoadReady}), 32'd0);
      chk("reset_insns", 32'({FetchInsn, LoadInsn}), 32'd0);
      chk("reset_busy", 32'(Busy), 32'd0);
      chk("reset_timeout_err", 32'(TimeoutErr), 32'd0);
      repeat (2) @(negedge Clk);
      Rst = 1'b0;

      mem_set(24'h000123, 4'h7);
      add_f(24'h000123, 2, 1'b0);
      run_round();
      add_l(24'h000010, 1'b1, 4'hA, 2, 1'b0);
      run_round();
      add_l(24'h000010, 1'b0, 4'h0, 1, 1'b0);
      run_round();
      add_f(24'h000123, 0, 1'b0);
      run_round();
      add_f(pool[0], 3, 1'b1);
      run_round();
      reset_mid(3);
      add_f(pool[1], 2, 1'b0);
      add_f(pool[3], 1, 1'b0);
      add_l(pool[2], 1'b0, 4'h0, 2, 1'b0);
      add_l(pool[4], 1'b1, 4'h3, 3, 1'b0);
      run_round();
      reset_mid(0);

      for (int r = 0; r < 40; r++) begin
         int nf, nl;
         nf = int'($urandom_range(0, 2));
         nl = int'($urandom_range(0, 2));
         if (nf + nl == 0) nf = 1;
         for (int i = 0; i < nf; i++)
            add_f(pool[$urandom_range(0, 7)], rand_d(), ($urandom_range(0, 3) == 0));
         for (int i = 0; i < nl; i++)
            add_l(pool[$urandom_range(0, 7)], 1'($urandom_range(0, 1)), IW'($urandom),
                  rand_d(), ($urandom_range(0, 3) == 0));
         run_round();
      end

      repeat (4) @(negedge Clk);
      chk("scoreboard_drained", 32'(expq.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ip_mem_arbiter.md
IP_MEM_ARBITER -- requirements
Module: ip_mem_arbiter

Interface
REQ-001 SHALL have parameters (name, default, meaning):
- ADDR_WIDTH, 24, instruction address width (6 dekatrons x 4 bits).
- INSN_WIDTH, 4, instruction word width.
- TIMEOUT, 15, maximum WAIT cycles before abort.

REQ-002 SHALL have ports (name, direction, width, meaning):
- Clk, in, 1, single clock; all state changes on its rising edge.
- Rst, in, 1, asynchronous active-high reset.
- FetchReq, in, 1, CPU fetch request (level).
- FetchAddr, in, ADDR_WIDTH, fetch address.
- FetchReady, out, 1, one-cycle fetch completion pulse.
- FetchInsn, out, INSN_WIDTH, fetched instruction.
- LoadReq, in, 1, loader request (level).
- LoadWE, in, 1, loader transaction is a write (1) or read-back (0).
- LoadAddr, in, ADDR_WIDTH, loader address.
- LoadData, in, INSN_WIDTH, loader write data.
- LoadReady, out, 1, one-cycle loader completion pulse.
- LoadInsn, out, INSN_WIDTH, loader read-back data.
- MemRequest, out, 1, request to instruction memory.
- MemWE, out, 1, memory write enable.
- MemAddress, out, ADDR_WIDTH, memory address.
- MemInsnIn, out, INSN_WIDTH, memory write data.
- MemInsnOut, in, INSN_WIDTH, memory read data.
- MemReady, in, 1, memory idle-and-done flag.
- Busy, out, 1, high whenever state is not IDLE.
- TimeoutErr, out, 1, sticky timeout flag.

Function
REQ-003 SHALL implement FSM IDLE, ISSUE, WAIT, DONE; DONE always returns to IDLE.
REQ-004 In IDLE, the FSM SHALL sample FetchReq and LoadReq at each edge.
- If either is high: latch winner, address, LoadWE and LoadData; go to ISSUE.
REQ-005 Arbitration SHALL be round-robin on a 1-bit LastGrant.
- Only one request high: that requester wins.
- Both high at the same edge: the requester not granted last wins.
- LastGrant updates on every grant.
REQ-006 In ISSUE (exactly one cycle):
- MemRequest=1.
- MemWE=1 only if the winner is the loader with LoadWE=1; else 0.
- Next state WAIT; WAIT counter cleared.
REQ-007 MemAddress and MemInsnIn SHALL hold the latched values from ISSUE through DONE; they are unchanged in IDLE.
REQ-008 In WAIT:
- MemRequest=0, MemWE=0.
- MemReady=1: capture MemInsnOut into the winner's data register; go to DONE.
- Otherwise: increment the counter.
REQ-009 If the counter reaches TIMEOUT in WAIT without MemReady:
- Go to DONE without capturing data.
- Set TimeoutErr=1 (held until Rst).
REQ-010 In DONE, the FSM SHALL pulse the winner's Ready for exactly one cycle; the other Ready stays 0.
REQ-011 FetchInsn/LoadInsn SHALL hold their last captured value until that requester's next successful read.
- Loader writes update neither output.
REQ-012 MemReady SHALL be ignored in IDLE, ISSUE and DONE.
REQ-013 A request dropped after grant SHALL NOT abort the transaction; its Ready still pulses.
REQ-014 A request still high in DONE SHALL be re-arbitrated as a new transaction at the next IDLE edge.
REQ-015 Latency with a memory that asserts Ready two cycles after Request:
- Req sampled at edge E0.
- MemRequest high in cycle E0+1.
- Ready high in cycle E0+4.
REQ-016 Address is passed unmodified (BCD digits not interpreted); the bootloader region is handled by the memory.

Reset
REQ-017 Rst=1 SHALL immediately, without waiting for Clk:
- Force state to IDLE.
- Set LastGrant=loader, so fetch wins the first tie.
- Clear WAIT counter, MemRequest, MemWE, MemAddress, MemInsnIn, FetchReady, LoadReady, FetchInsn, LoadInsn, Busy and TimeoutErr to 0.
REQ-018 Rst asserted mid-transaction SHALL drop MemRequest/MemWE at once, with no Ready pulse afterward.

Verification
REQ-019 Single fetch: FetchReq=1, FetchAddr=0x000123, memory returns 0x7 -> one MemRequest pulse, MemAddress=0x000123, FetchReady pulse 4 cycles after sampling, FetchInsn=0x7.
REQ-020 Loader write: LoadReq=1, LoadWE=1, LoadAddr=0x000010, LoadData=0xA -> MemWE=1 only in ISSUE with MemInsnIn=0xA, LoadReady pulse, FetchInsn and LoadInsn unchanged.
REQ-021 Tie after reset: FetchReq and LoadReq both held high -> grants alternate fetch, load, fetch, load; each Ready pulses once per grant.
REQ-022 Timeout: MemReady tied 0, FetchReq pulse -> DONE after 15 WAIT cycles, FetchReady pulse, TimeoutErr=1, FetchInsn unchanged.
REQ-023 Reset in WAIT: Rst=1 mid-fetch -> MemRequest=0 and Busy=0 the same cycle, no FetchReady, TimeoutErr=0.
REQ-024 Dropped request: FetchReq deasserted in WAIT -> transaction completes, FetchReady pulses once, no second MemRequest.
